// File: rtl/frame_buffer_scheduler_if.sv
// Processor-side request/response bus of the frame buffer scheduler.
// The master issues pixel accesses; the slave (scheduler) accepts them and returns read data.
interface frame_buffer_scheduler_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_data;
  logic                  rd_valid;
  logic                  rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Owns frame buffer port A: arbitrates queued processor pixel accesses against a
// full-screen clear engine that yields one slot after every CLEAR_BURST writes.
module frame_buffer_scheduler #(
  parameter int ADDR_WIDTH  = 15,
  parameter int FIFO_DEPTH  = 4,
  parameter int CLEAR_BURST = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  frame_buffer_scheduler_if.slave cpu,
  input  logic                  clr_start_i,
  input  logic                  clr_value_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  output logic [ADDR_WIDTH-1:0] fb_addr_o,
  output logic                  fb_data_in_o,
  output logic                  fb_we_o,
  input  logic                  fb_data_out_i
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BURST_W = $clog2(CLEAR_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_CLEAR, S_CLEAR_YIELD} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  data;
  } req_t;

  state_t                state_q, state_d;
  req_t                  fifo_mem [FIFO_DEPTH];
  req_t                  head;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;
  logic                  queue_busy;

  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic                  clr_val_q, clr_val_d;
  logic                  clr_busy_q, clr_busy_d;
  logic                  clr_done_q, clr_done_d;
  logic                  clr_accept, clr_last, burst_hit;

  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic                  fb_data_q, fb_data_d;
  logic                  fb_we_q, fb_we_d;
  logic                  rd_issue_q, rd_issue_d;
  logic                  rd_wait_q, rd_valid_q, rd_data_q;

  // READY comes from the registered count, so a same-cycle pop does not free a slot early.
  assign cpu.req_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push          = cpu.req_valid && cpu.req_ready;
  assign head          = fifo_mem[rd_ptr_q];
  assign queue_busy    = (count_q != '0);
  assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

  assign clr_accept = clr_start_i && !clr_busy_q;
  assign clr_last   = &clr_ptr_q;
  assign burst_hit  = (burst_q >= BURST_W'(CLEAR_BURST - 1));

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (clr_accept)      state_d = S_CLEAR;
        else if (queue_busy) state_d = S_CPU;
      end
      S_CPU: begin
        if (clr_accept)             state_d = S_CLEAR;
        else if (count_d == '0)     state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (clr_last)                     state_d = queue_busy ? S_CPU : S_IDLE;
        else if (burst_hit && queue_busy) state_d = S_CLEAR_YIELD;
      end
      S_CLEAR_YIELD: state_d = S_CLEAR;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    rd_issue_d = 1'b0;
    clr_ptr_d  = clr_ptr_q;
    burst_d    = burst_q;
    clr_val_d  = clr_val_q;
    case (state_q)
      S_CPU, S_CLEAR_YIELD: begin
        pop        = 1'b1;
        fb_we_d    = head.we;
        fb_addr_d  = head.addr;
        fb_data_d  = head.data;
        rd_issue_d = !head.we;
      end
      S_CLEAR: begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_ptr_q;
        fb_data_d = clr_val_q;
        clr_ptr_d = clr_ptr_q + 1'b1;
        // Saturate so a request arriving late in a long burst still gets the next slot.
        burst_d   = burst_hit ? BURST_W'(CLEAR_BURST) : burst_q + 1'b1;
      end
      default: ;
    endcase
    if (state_q == S_CLEAR_YIELD) burst_d = '0;
    if ((state_q == S_IDLE || state_q == S_CPU) && clr_accept) begin
      clr_ptr_d = '0;
      burst_d   = '0;
      clr_val_d = clr_value_i;
    end
    clr_busy_d = (state_q == S_CLEAR) || (state_q == S_CLEAR_YIELD);
    clr_done_d = clr_busy_q && !clr_busy_d;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: queue storage is left unreset; the pointers and count alone define which entries are valid.
    if (push) fifo_mem[wr_ptr_q] <= {cpu.req_we, cpu.req_addr, cpu.req_data};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      clr_ptr_q  <= '0;
      burst_q    <= '0;
      clr_val_q  <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= 1'b0;
      fb_we_q    <= 1'b0;
      rd_issue_q <= 1'b0;
      rd_wait_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      clr_ptr_q  <= clr_ptr_d;
      burst_q    <= burst_d;
      clr_val_q  <= clr_val_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
      // Port A read data arrives one cycle after the address; capture it the cycle after that.
      rd_issue_q <= rd_issue_d;
      rd_wait_q  <= rd_issue_q;
      rd_valid_q <= rd_wait_q;
      if (rd_wait_q) rd_data_q <= fb_data_out_i;
    end
  end

  assign cpu.rd_valid = rd_valid_q;
  assign cpu.rd_data  = rd_data_q;
  assign clr_busy_o   = clr_busy_q;
  assign clr_done_o   = clr_done_q;
  assign fb_addr_o    = fb_addr_q;
  assign fb_data_in_o = fb_data_q;
  assign fb_we_o      = fb_we_q;
endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Scoreboard bench for frame_buffer_scheduler: expected processor accesses are queued at
// issue time and matched against port A writes and read responses as they appear.
module tb_frame_buffer_scheduler;
  localparam int AW   = 15;
  localparam int NPIX = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_start, clr_value, clr_busy, clr_done;
  logic          fb_we, fb_data_in, fb_data_out;
  logic [AW-1:0] fb_addr;

  frame_buffer_scheduler_if #(.ADDR_WIDTH(AW)) cpu_if ();

  frame_buffer_scheduler #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4), .CLEAR_BURST(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cpu           (cpu_if),
    .clr_start_i   (clr_start),
    .clr_value_i   (clr_value),
    .clr_busy_o    (clr_busy),
    .clr_done_o    (clr_done),
    .fb_addr_o     (fb_addr),
    .fb_data_in_o  (fb_data_in),
    .fb_we_o       (fb_we),
    .fb_data_out_i (fb_data_out)
  );

  always #5 clk = ~clk;

  // Frame buffer port A model: synchronous read, data one cycle after address.
  bit fb_mem [NPIX];
  initial fb_data_out = 1'b0;
  always @(posedge clk) begin
    if (fb_we) fb_mem[fb_addr] <= fb_data_in;
    fb_data_out <= fb_mem[fb_addr];
  end

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_wr_q[$];
  logic        exp_rd_q[$];
  int          busy_cycles, clr_writes, done_count;
  logic [AW:0] clr_exp;
  logic        clr_fill;
  wr_t         mon_w;
  logic        mon_r;

  // Monitor: contiguous fill-value writes while busy belong to the clear; anything else is a processor access.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (clr_busy) busy_cycles++;
      if (clr_done) done_count++;
      if (fb_we) begin
        if (clr_busy && fb_addr == clr_exp[AW-1:0] && fb_data_in == clr_fill) begin
          clr_exp++;
          clr_writes++;
        end else begin
          checks++;
          if (exp_wr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h data=%b, required no write", fb_addr, fb_data_in);
          end else begin
            mon_w = exp_wr_q.pop_front();
            if ({fb_addr, fb_data_in} !== mon_w) begin
              errors++;
              $display("FAIL cpu_write: got addr=%h data=%b, required addr=%h data=%b",
                       fb_addr, fb_data_in, mon_w.addr, mon_w.data);
            end
          end
        end
      end
      if (cpu_if.rd_valid) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read: got rd_data=%b, required no response", cpu_if.rd_data);
        end else begin
          mon_r = exp_rd_q.pop_front();
          if (cpu_if.rd_data !== mon_r) begin
            errors++;
            $display("FAIL read_data: got %b, required %b", cpu_if.rd_data, mon_r);
          end
        end
      end
    end
  end

  task automatic drive_idle();
    cpu_if.req_valid = 1'b0;
    cpu_if.req_we    = 1'b0;
    cpu_if.req_addr  = '0;
    cpu_if.req_data  = 1'b0;
  endtask

  // Drives one request at a negedge and records its expectation if it will be accepted.
  task automatic offer_req(input logic we, input logic [AW-1:0] addr, input logic data, input logic rd_exp);
    cpu_if.req_valid = 1'b1;
    cpu_if.req_we    = we;
    cpu_if.req_addr  = addr;
    cpu_if.req_data  = data;
    checks++;
    if (cpu_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: got ready=%b, required 1 (addr=%h)", cpu_if.req_ready, addr);
    end else if (we) exp_wr_q.push_back({addr, data});
    else             exp_rd_q.push_back(rd_exp);
  endtask

  task automatic start_clear(input logic fill);
    clr_fill    = fill;
    clr_exp     = '0;
    busy_cycles = 0;
    clr_writes  = 0;
    done_count  = 0;
    clr_value   = fill;
    clr_start   = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    clr_value = ~fill;
    checks++;
    if ({clr_busy, fb_we} !== 2'b00) begin
      errors++;
      $display("FAIL clear_early: got busy=%b we=%b, required 0 0", clr_busy, fb_we);
    end
    @(negedge clk);
    checks++;
    if ({clr_busy, fb_we, fb_addr, fb_data_in} !== {1'b1, 1'b1, AW'(0), fill}) begin
      errors++;
      $display("FAIL clear_first_write: got busy=%b we=%b addr=%h data=%b, required 1 1 0000 %b",
               clr_busy, fb_we, fb_addr, fb_data_in, fill);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    clr_start = 1'b0;
    clr_value = 1'b0;
    clr_fill  = 1'b0;
    clr_exp   = '0;
    busy_cycles = 0;
    clr_writes  = 0;
    done_count  = 0;
    drive_idle();
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_if.req_ready, cpu_if.rd_valid, cpu_if.rd_data} !== 3'b100) begin
      errors++;
      $display("FAIL reset_cpu: got ready/rd_valid/rd_data=%b, required 100",
               {cpu_if.req_ready, cpu_if.rd_valid, cpu_if.rd_data});
    end
    checks++;
    if ({clr_busy, clr_done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_clear: got busy/done=%b, required 00", {clr_busy, clr_done});
    end
    checks++;
    if ({fb_we, fb_addr, fb_data_in} !== {1'b0, AW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_port: got we=%b addr=%h data=%b, required 0 0000 0", fb_we, fb_addr, fb_data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear_alone();
    logic          seen, prev_we;
    logic [AW-1:0] prev_addr;
    seen = 1'b0;
    start_clear(1'b1);
    prev_we   = fb_we;
    prev_addr = fb_addr;
    for (int n = 0; n < NPIX + 100 && !seen; n++) begin
      prev_we   = fb_we;
      prev_addr = fb_addr;
      @(negedge clk);
      if (clr_done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL clear_timeout: got no CLR_DONE, required one within %0d cycles", NPIX + 100);
    end else begin
      checks++;
      if ({clr_busy, fb_we, prev_we, prev_addr} !== {1'b0, 1'b0, 1'b1, AW'(NPIX - 1)}) begin
        errors++;
        $display("FAIL clear_done_cycle: got busy=%b we=%b prev_we=%b prev_addr=%h, required 0 0 1 %h",
                 clr_busy, fb_we, prev_we, prev_addr, AW'(NPIX - 1));
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (clr_writes != NPIX || busy_cycles != NPIX || done_count != 1) begin
      errors++;
      $display("FAIL clear_alone_len: got writes=%0d busy=%0d done=%0d, required %0d %0d 1",
               clr_writes, busy_cycles, done_count, NPIX, NPIX);
    end
  endtask

  task automatic test_write_read();
    offer_req(1'b1, AW'('h0305), 1'b1, 1'b0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL write_too_early: got we=%b, required 0", fb_we);
    end
    @(negedge clk);
    checks++;
    if ({fb_we, fb_addr} !== {1'b1, AW'('h0305)}) begin
      errors++;
      $display("FAIL write_latency: got we=%b addr=%h, required 1 0305", fb_we, fb_addr);
    end
    repeat (2) @(negedge clk);
    offer_req(1'b0, AW'('h0305), 1'b0, 1'b1);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({fb_we, fb_addr} !== {1'b0, AW'('h0305)}) begin
      errors++;
      $display("FAIL read_issue: got we=%b addr=%h, required 0 0305", fb_we, fb_addr);
    end
    @(negedge clk);
    checks++;
    if (cpu_if.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_too_early: got rd_valid=%b, required 0", cpu_if.rd_valid);
    end
    @(negedge clk);
    checks++;
    if ({cpu_if.rd_valid, cpu_if.rd_data} !== 2'b11) begin
      errors++;
      $display("FAIL read_latency: got rd_valid=%b rd_data=%b, required 1 1", cpu_if.rd_valid, cpu_if.rd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    offer_req(1'b1, AW'('h0306), 1'b0, 1'b0);
    @(negedge clk);
    offer_req(1'b0, AW'('h0306), 1'b0, 1'b0);
    @(negedge clk);
    offer_req(1'b0, AW'('h0305), 1'b0, 1'b1);
    @(negedge clk);
    drive_idle();
    n = 0;
    while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d writes %0d reads pending, required 0 0", exp_wr_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_yield_busy();
    logic seen, rd_sent, start_sent;
    seen = 1'b0;
    rd_sent = 1'b0;
    start_sent = 1'b0;
    start_clear(1'b0);
    for (int n = 0; n < NPIX + 200 && !seen; n++) begin
      drive_idle();
      clr_start = 1'b0;
      if (!rd_sent && fb_we && fb_addr == AW'(20)) begin
        offer_req(1'b0, AW'(0), 1'b0, 1'b0);
        rd_sent = 1'b1;
      end
      if (!start_sent && fb_we && fb_addr == AW'('h2000)) begin
        clr_value  = 1'b1;
        clr_start  = 1'b1;
        start_sent = 1'b1;
      end
      @(negedge clk);
      if (clr_done) seen = 1'b1;
    end
    drive_idle();
    clr_start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (!seen || !rd_sent || !start_sent) begin
      errors++;
      $display("FAIL yield_run: got done=%b read_sent=%b start_sent=%b, required 1 1 1", seen, rd_sent, start_sent);
    end
    checks++;
    if (clr_writes != NPIX || busy_cycles != NPIX + 1 || done_count != 1) begin
      errors++;
      $display("FAIL yield_len: got writes=%0d busy=%0d done=%0d, required %0d %0d 1",
               clr_writes, busy_cycles, done_count, NPIX, NPIX + 1);
    end
    checks++;
    if (exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL yield_read_pending: got %0d reads pending, required 0", exp_rd_q.size());
    end
  endtask

  task automatic test_full_queue_reset();
    int   n;
    logic found;
    start_clear(1'b1);
    for (int i = 0; i < 4; i++) begin
      offer_req(1'b1, AW'('h7000 + i), 1'b0, 1'b0);
      @(negedge clk);
    end
    checks++;
    if (cpu_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got ready=%b, required 0", cpu_if.req_ready);
    end
    cpu_if.req_valid = 1'b1;
    cpu_if.req_we    = 1'b1;
    cpu_if.req_addr  = AW'('h7100);
    cpu_if.req_data  = 1'b0;
    @(negedge clk);
    drive_idle();
    n = 0;
    while (exp_wr_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_wr_q.size() != 0 || busy_cycles - clr_writes != 4) begin
      errors++;
      $display("FAIL full_drain: got %0d pending gaps=%0d, required 0 4", exp_wr_q.size(), busy_cycles - clr_writes);
    end
    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      if (fb_we && fb_addr == AW'('h1000)) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_1000: got no write at 1000, required one within 5000 cycles");
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({fb_we, clr_busy, cpu_if.req_ready, clr_done} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_abort: got we/busy/ready/done=%b, required 0010",
               {fb_we, clr_busy, cpu_if.req_ready, clr_done});
    end
    rst_n = 1'b1;
    done_count = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_count != 0 || fb_we !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got done_pulses=%0d we=%b, required 0 0", done_count, fb_we);
    end
    start_clear(1'b1);
    repeat (40) @(negedge clk);
    checks++;
    if (clr_writes < 40 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL restart_progress: got writes=%0d pending=%0d, required >=40 0", clr_writes, exp_wr_q.size());
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clear_alone();
    test_write_read();
    test_back_to_back();
    test_yield_busy();
    test_full_queue_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
